// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
//   div_state_e : control FSM states (IDLE, CALC, FIX, DONE)
//   WIDTH_DEF   : default operand/result width
//   CNT_W       : iteration counter width
//   ITER        : number of restoring iterations per division
package div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = 6;
  localparam int ITER      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_seq_unit_if.sv
// div_seq_unit_if: request/result bundle between the CPU control FSM and
// the divider.
//   start       : one-cycle divide request (DivCtrl)
//   a, b        : dividend / divisor (RegA / RegB)
//   is_unsigned : DIVU select, present only when DIV_UNSIGNED_EN is defined
//   hi, lo      : remainder / quotient
//   done        : one-cycle completion pulse
//   div_zero    : sticky divide-by-zero flag (DivZero)
//   busy        : divider is not idle
// Modports: master (CPU side), slave (divider side).
// Optional feature macro: DIV_UNSIGNED_EN.
interface div_seq_unit_if
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef DIV_UNSIGNED_EN
  logic             is_unsigned;
`endif
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             done;
  logic             div_zero;
  logic             busy;

  modport master (
    output start, a, b,
`ifdef DIV_UNSIGNED_EN
    output is_unsigned,
`endif
    input  hi, lo, done, div_zero, busy
  );

  modport slave (
    input  start, a, b,
`ifdef DIV_UNSIGNED_EN
    input  is_unsigned,
`endif
    output hi, lo, done, div_zero, busy
  );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_i     : partial remainder (always < divisor_i)
//   q_msb_i   : next dividend bit shifted into the remainder
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder after this step
//   q_bit_o   : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  // One extra bit: with an unsigned divisor near 2^WIDTH the shifted
  // remainder can exceed WIDTH bits before the subtraction.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted = {rem_i, q_msb_i};
  assign q_bit_o = (shifted >= {1'b0, divisor_i});
  // The true difference is below the divisor, so WIDTH bits hold it exactly.
  assign diff    = shifted[WIDTH-1:0] - divisor_i;
  assign rem_o   = q_bit_o ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq_unit.sv
// div_seq_unit: sequential signed divider, one quotient bit per clock.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset, aborts any operation
//   bus   : div_seq_unit_if.slave (start/a/b in; hi/lo/done/div_zero/busy out)
// A start accepted in IDLE latches operand magnitudes and result signs,
// runs ITER restoring steps in CALC, applies signs in FIX and pulses done
// in DONE. Divide by zero skips straight to DONE with div_zero set and
// hi/lo untouched.
// Optional feature macro: DIV_UNSIGNED_EN (adds bus.is_unsigned for DIVU).
module div_seq_unit
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic          clock,
  input  logic          reset,
  div_seq_unit_if.slave bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_zero_q, div_zero_d;

  logic             uns;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

`ifdef DIV_UNSIGNED_EN
  assign uns = bus.is_unsigned;
`else
  assign uns = 1'b0;
`endif

  // Magnitudes in WIDTH-bit unsigned: the most negative value maps to itself,
  // which is what makes MIN / -1 wrap without a special case.
  assign a_mag = (!uns && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (!uns && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // The quotient register doubles as the dividend shift register: its MSB
  // feeds the remainder while the new quotient bit enters at the LSB.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .q_msb_i   (quo_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          neg_quo_d  = !uns && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_rem_d  = !uns && bus.a[WIDTH-1];
          div_zero_d = 1'b0;
          if (bus.b == '0) begin
            div_zero_d = 1'b1;
            state_d    = DONE;
          end else begin
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = a_mag;
            divisor_d = b_mag;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = neg_quo_q ? -quo_q : quo_q;
        hi_d    = neg_rem_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = div_zero_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_div_seq_unit.sv
// tb_div_seq_unit: scoreboard bench for div_seq_unit. Each request pushes
// its expected {lo, hi, div_zero} and a monitor pops/compares on every done.
module tb_div_seq_unit;
  import div_pkg::*;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  div_seq_unit_if #(.WIDTH(32)) bus ();

  div_seq_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && bus.done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("lo", bus.lo, e.lo);
        chk("hi", bus.hi, e.hi);
        chk("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
        $display("done: lo=0x%08h hi=0x%08h div_zero=%0b", bus.lo, bus.hi, bus.div_zero);
      end
    end
  end

  // Start is presented before edge N and removed just after it.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clock);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  // Runs one operation, measures done latency in cycles after the accepting
  // edge, and optionally pulses a stray start (1/1) at cycles inj1/inj2.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic exp_dz, input int exp_lat, input int inj1, input int inj2);
    exp_t e;
    int   lat;
    bit   got;
    e.lo = exp_lo;
    e.hi = exp_hi;
    e.dz = exp_dz;
    sb_q.push_back(e);
    $display("start %s: a=0x%08h b=0x%08h", tag, av, bv);
    issue(av, bv);
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 60 && !got; c++) begin
      @(negedge clock);
      bus.start = 1'b0;
      if (c == 1) begin
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        if (exp_lat > 1) chk({tag, "_dz_cleared"}, {31'd0, bus.div_zero}, 32'd0);
      end
      if (bus.done) begin
        got = 1'b1;
        lat = c;
      end
      if (c == inj1 || c == inj2) begin
        bus.start = 1'b1;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    @(negedge clock);
    bus.start = 1'b0;
    chk({tag, "_done_single"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef DIV_UNSIGNED_EN
    bus.is_unsigned = 1'b0;
`endif
    repeat (3) @(negedge clock);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_dz", {31'd0, bus.div_zero}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 0, 0);
    run_op("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 0, 0);
    run_op("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 0, 0);

    // Divide by zero keeps the previous result and a sticky flag.
    run_op("100/7b", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 0, 0);
    run_op("5/0", 32'd5, 32'd0, 32'd14, 32'd2, 1'b1, 1, 0, 0);
    repeat (5) @(negedge clock);
    chk("dz_sticky", {31'd0, bus.div_zero}, 32'd1);
    chk("dz_lo_held", bus.lo, 32'd14);
    chk("dz_hi_held", bus.hi, 32'd2);
    run_op("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 0, 0);

    run_op("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, 0, 0);

    // Random signed operations against the language's own division.
    for (int i = 0; i < 4; i++) begin
      int sa, sbv;
      sa  = $urandom;
      sbv = $urandom_range(1, 5000);
      if (i[0]) sbv = -sbv;
      run_op("rand", sa, sbv, sa / sbv, sa % sbv, 1'b0, 34, 0, 0);
    end

`ifdef DIV_UNSIGNED_EN
    bus.is_unsigned = 1'b1;
    run_op("divu", 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 34, 0, 0);
    bus.is_unsigned = 1'b0;
`endif

    // Reset in the middle of a calculation aborts without a done pulse.
    $display("start abort: a=0x%08h b=0x%08h", 32'd100, 32'd7);
    issue(32'd100, 32'd7);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_dz", {31'd0, bus.div_zero}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_op("20/3", 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 34, 0, 0);

    // Starts while busy and in the DONE cycle are ignored.
    run_op("ignore", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 5, 34);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done || bus.busy) seen++;
    end
    chk("ignore_no_second", seen, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
